// File: rtl/frac_reduce.sv
// frac_reduce: divides num and den by g with parallel restoring dividers, flags inexact or zero g.
module frac_reduce #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] num,
  input  logic [W-1:0] den,
  input  logic [W-1:0] g,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] num_r,
  output logic [W-1:0] den_r,
  output logic         err
);
  localparam int CW = $clog2(W);
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
  state_t state, state_n;
  logic [W-1:0] a_n, a_d, gr, r_n, r_d, na_n, na_d;
  logic [W:0] t_n, t_d, nr_n, nr_d;
  logic [CW-1:0] cnt;
  logic ge_n, ge_d, last;
  // One restoring step per cycle: shift the next dividend bit into the remainder, subtract if it fits.
  always_comb begin
    t_n = {r_n, a_n[W-1]};
    t_d = {r_d, a_d[W-1]};
    ge_n = t_n >= {1'b0, gr};
    ge_d = t_d >= {1'b0, gr};
    nr_n = ge_n ? t_n - {1'b0, gr} : t_n;
    nr_d = ge_d ? t_d - {1'b0, gr} : t_d;
    na_n = {a_n[W-2:0], ge_n};
    na_d = {a_d[W-2:0], ge_d};
    last = cnt == CW'(W - 1);
    state_n = state == IDLE ? (in_valid ? (g == '0 ? DONE : DIV) : IDLE)
            : state == DIV  ? (last ? DONE : DIV)
            : (out_ready ? IDLE : DONE);
  end
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      num_r <= '0;
      den_r <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && in_valid) begin
        a_n   <= num;
        a_d   <= den;
        gr    <= g;
        r_n   <= '0;
        r_d   <= '0;
        cnt   <= '0;
        num_r <= '0;
        den_r <= '0;
        err   <= g == '0;
      end
      if (state == DIV) begin
        a_n <= na_n;
        a_d <= na_d;
        r_n <= nr_n[W-1:0];
        r_d <= nr_d[W-1:0];
        cnt <= cnt + 1'b1;
        if (last) begin
          num_r <= na_n;
          den_r <= na_d;
          err   <= (|nr_n) | (|nr_d);
        end
      end
    end
  end
endmodule

// File: tb/tb_frac_reduce.sv
// tb_frac_reduce: table-driven and randomized checks of frac_reduce against plain-arithmetic expectations.
module tb_frac_reduce;
  localparam int W = 8;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, err;
  logic [W-1:0] num = 0, den = 0, g = 0, num_r, den_r;
  int n_cmp = 0, n_bad = 0;

  frac_reduce #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .num(num), .den(den), .g(g), .out_valid(out_valid), .out_ready(out_ready),
    .num_r(num_r), .den_r(den_r), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] n, d, gg, en, ed;
    logic ee;
    int hold;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [W-1:0] n, d, gg, en, ed, input logic ee, input int hold, input string nm);
    int lat;
    chk({nm, ".in_ready_idle"}, in_ready, 1);
    num = n; den = d; g = gg; in_valid = 1; out_ready = 0;
    tick();
    lat = 0;
    while (!out_valid && lat < 40) begin
      in_valid = 1'($urandom); num = W'($urandom); den = W'($urandom); g = W'($urandom);
      tick();
      lat++;
    end
    in_valid = 0;
    chk({nm, ".latency"}, lat, gg == 0 ? 0 : W);
    chk({nm, ".num_r"}, num_r, en);
    chk({nm, ".den_r"}, den_r, ed);
    chk({nm, ".err"}, err, ee);
    for (int k = 0; k < hold; k++) begin
      tick();
      chk({nm, ".hold"}, {out_valid, in_ready, err, den_r, num_r}, {1'b1, 1'b0, ee, ed, en});
    end
    out_ready = 1;
    tick();
    out_ready = 0;
    chk({nm, ".consumed"}, {out_valid, in_ready}, 2'b01);
  endtask

  task automatic model_op(input logic [W-1:0] n, d, gg, input int hold, input string nm);
    logic [W-1:0] en, ed;
    logic ee;
    en = gg == 0 ? '0 : n / gg;
    ed = gg == 0 ? '0 : d / gg;
    ee = gg == 0 || (n % gg) != 0 || (d % gg) != 0;
    op(n, d, gg, en, ed, ee, hold, nm);
  endtask

  vec_t tbl[$];

  initial begin
    tbl = '{
      '{144, 60, 12, 12, 5, 0, 0},
      '{70, 45, 5, 14, 9, 0, 1},
      '{14, 43, 1, 14, 43, 0, 0},
      '{40, 24, 16, 2, 1, 1, 2},
      '{0, 27, 27, 0, 1, 0, 0},
      '{5, 15, 0, 0, 0, 1, 1},
      '{45, 60, 15, 3, 4, 0, 5},
      '{255, 255, 1, 255, 255, 0, 0},
      '{255, 1, 255, 1, 0, 1, 0},
      '{200, 100, 50, 4, 2, 0, 0},
      '{0, 0, 7, 0, 0, 0, 0}
    };
    tick(); tick();
    chk("reset.state", {out_valid, in_ready, err, den_r, num_r}, {1'b0, 1'b1, 1'b0, 8'd0, 8'd0});
    rst = 0;
    tick();
    foreach (tbl[i]) op(tbl[i].n, tbl[i].d, tbl[i].gg, tbl[i].en, tbl[i].ed, tbl[i].ee, tbl[i].hold, $sformatf("vec%0d", i));
    // reset on the 4th DIV cycle discards the operation
    num = 20; den = 87; g = 1; in_valid = 1;
    tick();
    in_valid = 0;
    tick(); tick(); tick();
    chk("abort.in_div", {out_valid, in_ready}, 2'b00);
    rst = 1;
    tick();
    rst = 0;
    chk("abort.after", {out_valid, in_ready, err, den_r, num_r}, {1'b0, 1'b1, 1'b0, 8'd0, 8'd0});
    for (int k = 0; k < W + 2; k++) tick();
    chk("abort.no_result", {out_valid, in_ready}, 2'b01);
    op(18, 54, 18, 1, 3, 0, 0, "after_abort");
    // reset wins over a simultaneous output handshake
    num = 9; den = 6; g = 3; in_valid = 1;
    tick();
    in_valid = 0;
    for (int k = 0; k < W; k++) tick();
    chk("done_rst.valid", out_valid, 1);
    rst = 1; out_ready = 1;
    tick();
    rst = 0; out_ready = 0;
    chk("done_rst.after", {out_valid, in_ready, err, den_r, num_r}, {1'b0, 1'b1, 1'b0, 8'd0, 8'd0});
    // reset wins over a simultaneous input handshake
    num = 9; den = 6; g = 0; in_valid = 1; rst = 1;
    tick();
    rst = 0; in_valid = 0;
    chk("idle_rst.no_accept", {out_valid, in_ready, err}, 3'b010);
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] gg, n, d;
      int sel;
      sel = $urandom_range(0, 3);
      gg = sel == 0 ? '0 : W'($urandom_range(1, 20));
      n = (sel == 1 && gg != 0) ? W'(gg * $urandom_range(0, 255 / gg)) : W'($urandom);
      d = (sel == 1 && gg != 0) ? W'(gg * $urandom_range(0, 255 / gg)) : W'($urandom);
      if (sel == 3) gg = W'($urandom_range(1, 255));
      model_op(n, d, gg, $urandom_range(0, 3), $sformatf("rnd%0d", i));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
